ixc_time_delta_gen: RTL and testbench

//  Time-advance scheduler that drives the delta bus consumed by emulated clock sources.

---
 rtl/ixc_time_delta_gen.sv | 88 ++++++++
 tb/tb_ixc_time_delta_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ixc_time_delta_gen.sv
// ixc_time_delta_gen: nearest-edge time-advance scheduler publishing delta/fire for emulated clock sources.
// Define IXC_TIME_ACCUM_EN to add the 48-bit running-time output `now`.
module ixc_time_delta_gen #(
    parameter int NSRC = 4,
    parameter int TW   = 10
) (
    input  logic            eclk,
    input  logic            reset,
    input  logic            cfg_we,
    input  logic [3:0]      cfg_idx,
    input  logic [TW-1:0]   cfg_half,
    output logic            cfg_rej,
    input  logic            step_req,
    output logic            step_ack,
    output logic [TW:0]     delta,
    output logic [NSRC-1:0] fire,
`ifdef IXC_TIME_ACCUM_EN
    output logic [47:0]     now,
`endif
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, SCAN, ISSUE} stateT;
    stateT state, nextState;
    logic [TW-1:0] half [NSRC];
    logic [TW-1:0] rem [NSRC];
    logic [4:0] scanIdx;
    logic [TW-1:0] minVal, curHalf, curRem;
    logic found;
    logic [NSRC-1:0] fireVec;
    assign busy = state != IDLE;
    assign cfg_rej = cfg_we && busy;
    always_comb begin
        nextState = (state == IDLE) ? (step_req ? SCAN : IDLE) :
                    (state == SCAN) ? ((scanIdx == 5'(NSRC - 1)) ? ISSUE : SCAN) : IDLE;
        curHalf = '0;
        curRem = '0;
        fireVec = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (scanIdx == 5'(i)) begin
                curHalf = half[i];
                curRem = rem[i];
            end
            fireVec[i] = found && half[i] != '0 && rem[i] == minVal;
        end
    end
    always_ff @(posedge eclk) state <= reset ? IDLE : nextState;
    always_ff @(posedge eclk) begin
        if (reset) begin
            scanIdx <= '0;
            minVal <= '0;
            found <= 1'b0;
            delta <= '0;
            fire <= '0;
            step_ack <= 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                half[i] <= '0;
                rem[i] <= '0;
            end
`ifdef IXC_TIME_ACCUM_EN
            now <= '0;
`endif
        end else begin
            step_ack <= state == ISSUE;
            scanIdx <= (state == SCAN) ? scanIdx + 5'd1 : '0;
            if (state == IDLE) found <= 1'b0;
            if (state == SCAN && curHalf != '0 && (!found || curRem < minVal)) begin
                minVal <= curRem;
                found <= 1'b1;
            end
            if (state == ISSUE) begin
                delta <= found ? {1'b0, minVal} : {1'b1, {TW{1'b0}}};
                fire <= fireVec;
`ifdef IXC_TIME_ACCUM_EN
                if (found) now <= now + 48'(minVal);
`endif
            end
            // config writes only land in IDLE, so rem is stable across a scan and its issue
            for (int i = 0; i < NSRC; i++) begin
                if (state == IDLE && cfg_we && cfg_idx == 4'(i)) begin
                    half[i] <= cfg_half;
                    rem[i] <= cfg_half;
                end else if (state == ISSUE && found && half[i] != '0) begin
                    rem[i] <= fireVec[i] ? half[i] : rem[i] - minVal;
                end
            end
        end
    end
endmodule

// File: tb/tb_ixc_time_delta_gen.sv
// tb_ixc_time_delta_gen: scoreboard bench for the time-delta scheduler.
// Expected delta/fire are queued at step request and popped on step_ack.
module tb_ixc_time_delta_gen;
    localparam int NSRC = 4;
    localparam int TW = 10;
    localparam logic [TW:0] NOEV = 11'h400;
    logic eclk = 1'b0;
    logic reset, cfg_we, step_req, cfg_rej, step_ack, busy;
    logic [3:0] cfg_idx;
    logic [TW-1:0] cfg_half;
    logic [TW:0] delta;
    logic [NSRC-1:0] fire;
    logic [47:0] expNow;
`ifdef IXC_TIME_ACCUM_EN
    logic [47:0] now;
`endif
    int errors = 0;
    int checks = 0;
    typedef struct {
        logic [TW:0] d;
        logic [NSRC-1:0] f;
    } expT;
    expT sb[$];

    ixc_time_delta_gen #(.NSRC(NSRC), .TW(TW)) dut (
        .eclk(eclk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_half(cfg_half),
        .cfg_rej(cfg_rej), .step_req(step_req), .step_ack(step_ack), .delta(delta), .fire(fire),
`ifdef IXC_TIME_ACCUM_EN
        .now(now),
`endif
        .busy(busy)
    );

    always #5 eclk = ~eclk;

    task automatic doReset;
        reset = 1'b1;
        repeat (2) @(negedge eclk);
        reset = 1'b0;
        expNow = '0;
    endtask

    task automatic cfg(input int idx, input int h);
        cfg_we = 1'b1;
        cfg_idx = 4'(idx);
        cfg_half = TW'(h);
        @(negedge eclk);
        cfg_we = 1'b0;
    endtask

    task automatic push(input logic [TW:0] d, input logic [NSRC-1:0] f);
        expT e;
        e.d = d;
        e.f = f;
        sb.push_back(e);
        if (!d[TW]) expNow = expNow + 48'(d[TW-1:0]);
    endtask

    task automatic awaitAck(input int already, input string name);
        int cnt;
        expT e;
        cnt = already;
        while (!step_ack && cnt < 20) begin
            @(negedge eclk);
            cnt++;
            step_req = 1'b0;
        end
        e = sb.pop_front();
        checks++;
        if (!step_ack) begin
            errors++;
            $display("FAIL %s ack: no step_ack within %0d cycles", name, cnt);
        end else begin
            checks += 3;
            if (delta !== e.d) begin errors++; $display("FAIL %s delta: got %h want %h", name, delta, e.d); end
            if (fire !== e.f) begin errors++; $display("FAIL %s fire: got %b want %b", name, fire, e.f); end
            if (cnt - 1 != NSRC + 1) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, cnt - 1, NSRC + 1); end
`ifdef IXC_TIME_ACCUM_EN
            checks++;
            if (now !== expNow) begin errors++; $display("FAIL %s now: got %0d want %0d", name, now, expNow); end
`endif
            @(negedge eclk);
            checks += 2;
            if (step_ack !== 1'b0) begin errors++; $display("FAIL %s ack pulse: got %b want 0", name, step_ack); end
            if (delta !== e.d) begin errors++; $display("FAIL %s delta hold: got %h want %h", name, delta, e.d); end
        end
    endtask

    task automatic runStep(input logic [TW:0] d, input logic [NSRC-1:0] f, input string name);
        push(d, f);
        step_req = 1'b1;
        awaitAck(0, name);
    endtask

    task automatic test_reset;
        doReset();
        checks += 5;
        if (delta !== '0) begin errors++; $display("FAIL reset delta: got %h want 0", delta); end
        if (fire !== '0) begin errors++; $display("FAIL reset fire: got %b want 0", fire); end
        if (step_ack !== 1'b0) begin errors++; $display("FAIL reset ack: got %b want 0", step_ack); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        if (cfg_rej !== 1'b0) begin errors++; $display("FAIL reset cfg_rej: got %b want 0", cfg_rej); end
    endtask

    task automatic test_sequence;
        doReset();
        cfg(0, 3);
        cfg(1, 5);
        runStep(11'd3, 4'b0001, "t1s1");
        runStep(11'd2, 4'b0010, "t1s2");
        runStep(11'd1, 4'b0001, "t1s3");
        runStep(11'd3, 4'b0001, "t1s4");
        cfg(0, 0);
        cfg(1, 0);
        runStep(NOEV, 4'b0000, "t1idle");
    endtask

    task automatic test_idle;
        doReset();
        cfg(5, 1);
        cfg(15, 7);
        runStep(NOEV, 4'b0000, "t2idle");
    endtask

    task automatic test_back_to_back;
        int cyc, acks, lastAck;
        expT e;
        doReset();
        cfg(0, 4);
        cfg(1, 4);
        cfg(2, 2);
        push(11'd2, 4'b0100);
        push(11'd2, 4'b0111);
        step_req = 1'b1;
        cyc = 0;
        acks = 0;
        lastAck = 0;
        while (acks < 2 && cyc < 40) begin
            @(negedge eclk);
            cyc++;
            if (step_ack) begin
                e = sb.pop_front();
                acks++;
                checks += 2;
                if (delta !== e.d) begin errors++; $display("FAIL b2b%0d delta: got %h want %h", acks, delta, e.d); end
                if (fire !== e.f) begin errors++; $display("FAIL b2b%0d fire: got %b want %b", acks, fire, e.f); end
                if (acks == 2) begin
                    step_req = 1'b0;
                    checks++;
                    if (cyc - lastAck != NSRC + 2) begin errors++; $display("FAIL b2b gap: got %0d want %0d", cyc - lastAck, NSRC + 2); end
                end
                lastAck = cyc;
            end
        end
        step_req = 1'b0;
        checks++;
        if (acks != 2) begin errors++; $display("FAIL b2b acks: got %0d want 2", acks); end
        while (sb.size() > 0) void'(sb.pop_front());
        @(negedge eclk);
    endtask

    task automatic test_cfg_reject;
        doReset();
        cfg(0, 6);
        push(11'd6, 4'b0001);
        step_req = 1'b1;
        @(negedge eclk);
        step_req = 1'b0;
        cfg_we = 1'b1;
        cfg_idx = 4'd0;
        cfg_half = 10'd1;
        #1;
        checks++;
        if (cfg_rej !== 1'b1) begin errors++; $display("FAIL t4 cfg_rej: got %b want 1", cfg_rej); end
        @(negedge eclk);
        cfg_we = 1'b0;
        #1;
        checks++;
        if (cfg_rej !== 1'b0) begin errors++; $display("FAIL t4 cfg_rej pulse: got %b want 0", cfg_rej); end
        awaitAck(2, "t4s1");
        runStep(11'd6, 4'b0001, "t4s2");
    endtask

    task automatic test_reset_mid_scan;
        int seen;
        doReset();
        cfg(0, 3);
        step_req = 1'b1;
        @(negedge eclk);
        step_req = 1'b0;
        @(negedge eclk);
        reset = 1'b1;
        @(negedge eclk);
        reset = 1'b0;
        expNow = '0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t5 busy: got %b want 0", busy); end
        seen = 0;
        repeat (NSRC + 3) begin
            @(negedge eclk);
            if (step_ack) seen++;
        end
        checks += 2;
        if (seen != 0) begin errors++; $display("FAIL t5 ack: got %0d acks want 0", seen); end
        if (delta !== '0) begin errors++; $display("FAIL t5 delta: got %h want 0", delta); end
        runStep(NOEV, 4'b0000, "t5after");
    endtask

    initial begin
        reset = 1'b1;
        cfg_we = 1'b0;
        step_req = 1'b0;
        cfg_idx = '0;
        cfg_half = '0;
        expNow = '0;
        @(negedge eclk);
        test_reset();
        test_sequence();
        test_idle();
        test_back_to_back();
        test_cfg_reject();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
